// File: rtl/bcd_conv_arbiter.sv
// Shared iterative 8-bit binary-to-BCD engine (shift/add-3) arbitrated among N requesters.
// Define BCD_ARB_FIXED_PRIO_EN for fixed priority; default build is round-robin.
module bcd_conv_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic           clock,
  input  logic           reset_,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] x,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic [3:0]     a3_a0,
  output logic [3:0]     b3_b0,
  output logic [3:0]     c3_c0,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    SHIFT,
    RESULT
  } state_t;

  state_t        st;
  logic [19:0]   s;
  logic [2:0]    count;
  logic [PW-1:0] w;
  logic [PW-1:0] pick;
`ifndef BCD_ARB_FIXED_PRIO_EN
  logic [PW-1:0] ptr;
`endif

  function automatic logic [3:0] add3(input logic [3:0] v);
    return (v >= 4'd5) ? v + 4'd3 : v;
  endfunction

`ifdef BCD_ARB_FIXED_PRIO_EN
  // Lowest asserted index wins; scan high-to-low so the lowest sticks
  always_comb begin
    pick = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[PW'(i)]) pick = PW'(i);
    end
  end
`else
  // First asserted request after the pointer, wrapping at N
  always_comb begin
    logic [PW-1:0] id;
    pick = '0;
    id   = '0;
    for (int k = N; k >= 1; k--) begin
      id = PW'((int'(ptr) + k) % N);
      if (req[id]) pick = id;
    end
  end
`endif

  // Arbitration, operand load, add-3/shift sequencing and handshake close
  always_ff @(posedge clock or posedge reset_) begin
    if (reset_) begin
      st    <= IDLE;
      s     <= '0;
      count <= '0;
      w     <= '0;
      gnt   <= '0;
      done  <= '0;
      a3_a0 <= '0;
      b3_b0 <= '0;
      c3_c0 <= '0;
      busy  <= 1'b0;
`ifndef BCD_ARB_FIXED_PRIO_EN
      ptr   <= PW'(N - 1);
`endif
    end else begin
      unique case (st)
        IDLE: begin
          if (|req) begin
            w     <= pick;
            gnt   <= N'(1) << pick;
            s     <= {12'b0, x[8*pick +: 8]};
            count <= 3'd7;
            busy  <= 1'b1;
            st    <= ADD;
          end
        end
        ADD: begin
          s  <= {add3(s[19:16]), add3(s[15:12]),
                 add3(s[11:8]), s[7:0]};
          st <= SHIFT;
        end
        SHIFT: begin
          s <= {s[18:0], 1'b0};
          if (count == 3'd0) begin
            {a3_a0, b3_b0, c3_c0} <= s[18:7];
            done <= N'(1) << w;
            st   <= RESULT;
          end else begin
            count <= count - 3'd1;
            st    <= ADD;
          end
        end
        RESULT: begin
          if (!req[w]) begin
            done <= '0;
            gnt  <= '0;
            busy <= 1'b0;
`ifndef BCD_ARB_FIXED_PRIO_EN
            ptr  <= w;
`endif
            st   <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
- Shares one iterative 8-bit binary-to-BCD engine (shift/add-3, three BCD digits) among N requesters.
- Each requester uses a 4-phase req/done handshake. The block arbitrates, latches the winner's operand and sequences the add-3/shift iterations.
- It publishes the hundreds/tens/units digits on a shared result bus.
- It sits between the display/formatting clients and the conversion datapath, which is embedded in this block.

Parameters:
- N, 4, number of requesters (legal 2..8).
- PW, 2, round-robin pointer width; must be at least clog2(N).

Ports:
- clock  input  1  system clock, all state changes on the rising edge.
- reset_  input  1  asynchronous reset, active-high (asserted at 1); when 1, forces all state to its reset value immediately.
- req  input  N  request vector; req[i] is held at 1 by requester i until done[i] is seen.
- x  input  8*N  operands; x[8i+7:8i] belongs to requester i and must be stable while req[i]=1.
- gnt  output  N  one-hot grant; bit i is 1 from operand load until the handshake closes.
- done  output  N  done[i]=1 means the result bus holds requester i's conversion.
- a3_a0  output  4  hundreds digit.
- b3_b0  output  4  tens digit.
- c3_c0  output  4  units digit.
- busy  output  1  1 in every state except IDLE.

Behaviour:
- Reset values:
  - gnt=0, done=0, busy=0.
  - a3_a0=b3_b0=c3_c0=0.
  - Internal 20-bit shift register s=0, 3-bit count=0.
  - Pointer = N-1, so requester 0 has first priority.
  - State = IDLE.
- Reset mid-conversion aborts the conversion with no done pulse.
- States are IDLE, ADD, SHIFT, RESULT.
- IDLE:
  - If req==0, stay.
  - Otherwise pick the winner w: the first set bit searching from pointer+1 upward, wrapping at N.
  - On that edge: gnt<=onehot(w), s<={12'b0, x_w}, count<=7, next state ADD.
- ADD:
  - Each 4-bit field s[19:16], s[15:12], s[11:8] gets +3 if its value is 5 or more.
  - s[7:0] is unchanged.
  - Next state SHIFT.
- SHIFT:
  - s<=s<<1 (zero fill).
  - If count==0: latch {a3_a0,b3_b0,c3_c0}<=(s<<1)[19:8], done[w]<=1, next state RESULT.
  - Else: count<=count-1, next state ADD.
- RESULT:
  - Hold done[w] and gnt[w].
  - When req[w]==0 is sampled: done<=0, gnt<=0, pointer<=w, next state IDLE.
- Latency:
  - Edge 1 samples req in IDLE.
  - 16 more edges (8 ADD/SHIFT pairs) follow.
  - done[w] is 1 after edge 17.
  - Minimum turnaround is 19 edges: one edge to close the handshake, then a new request can be sampled in IDLE on the following edge.
- The result bus holds its last value until the next conversion completes, independent of done.
- At most one done bit and one gnt bit are ever 1.
- Requests arriving during a conversion wait; they are never lost while req stays high.
- A winner that drops req before done is a protocol violation. The conversion still completes, done[w] is 1 for exactly one cycle, then the block returns to IDLE.
- x of non-granted requesters and x_w after the load edge are ignored.
- Simultaneous requests: exactly one grant per arbitration, chosen round-robin (see Optional Feature).

Optional Feature:
- Macro: BCD_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index asserted req always wins, and the pointer is not used.
- Undefined (default): round-robin as above. With all N requesters held high continuously, every requester is granted once per N conversions.

Test Plan:
- Reset, then req=0001, x0=8'd255 -> gnt=0001; done[0]=1 after exactly 17 edges; a=2, b=5, c=5. Drop req[0] -> next edge done=0, gnt=0, busy=0.
- Single requests, one at a time:
  - x=0 -> 0,0,0.
  - x=9 -> 0,0,9.
  - x=10 -> 0,1,0.
  - x=99 -> 0,9,9.
  - x=100 -> 1,0,0.
  - x=128 -> 1,2,8.
- Boundary sweep: x=0..255 on requester 2 -> every result equals the decimal digits of x, and every done arrives at edge 17.
- req=1111 held high with distinct x (11, 22, 33, 44), each requester re-raising after its done:
  - Round-robin build: grants 0,1,2,3,0,...
  - With BCD_ARB_FIXED_PRIO_EN: requester 0 is granted on every arbitration.
- Assert reset_=1 at edge 8 of a conversion (x=200) -> all outputs are 0 immediately, with no clock edge needed. After release, the held req[0] restarts and returns 2,0,0.
- req[1] raised with x1=37, then dropped at edge 5 -> done[1]=1 for exactly one cycle with 0,3,7, then IDLE; a pending req[3] is then granted.
